// File: rtl/vmux_stream.sv
// Registered N:1 operand selector with direct (one word per request) and sweep (all channels in index order) modes.
// Optional build macro VMUX_STREAM_PARITY_EN adds out_parity, the XOR of the word loaded into out_data.
module vmux_stream #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    start,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_tag,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef VMUX_STREAM_PARITY_EN
    output logic                    out_parity,
`endif
    output logic                    busy,
    output logic                    done
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Parameter sanity checks at elaboration
    if (WIDTH < 1) begin : g_bad_width
        $error("vmux_stream: WIDTH must be >= 1");
    end
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("vmux_stream: NUM_IN must be in 2..16");
    end
    if ((64'd1 << SEL_W) < 64'(NUM_IN)) begin : g_bad_sel_w
        $error("vmux_stream: SEL_W too narrow for NUM_IN");
    end

    state_t             r_state;
    logic [SEL_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_tag;
    logic               r_out_err;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_load_ok;
    logic               w_req_ready;
    logic               w_direct_load;
    logic               w_sweep_load;
    logic               w_load;
    logic               w_last;
    logic [SEL_W-1:0]   w_pick_sel;
    logic [WIDTH-1:0]   w_pick_data;
    logic               w_pick_hit;

    assign w_load_ok     = !r_out_valid || out_ready;
    assign w_req_ready   = (r_state == ST_IDLE) && !start && w_load_ok;
    assign w_direct_load = w_req_ready && req_valid;
    assign w_sweep_load  = (r_state == ST_SWEEP) && w_load_ok;
    assign w_load        = w_direct_load || w_sweep_load;
    assign w_last        = (r_idx == SEL_W'(NUM_IN - 1));
    assign w_pick_sel    = (r_state == ST_SWEEP) ? r_idx : sel;

    // Channel mux; a select with no matching channel yields zero and a miss
    always_comb begin
        w_pick_data = '0;
        w_pick_hit  = 1'b0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (w_pick_sel == SEL_W'(k)) begin
                w_pick_data = in_data[k*WIDTH +: WIDTH];
                w_pick_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_load) begin
                r_out_data  <= w_pick_data;
                r_out_tag   <= w_pick_sel;
                r_out_err   <= !w_pick_hit;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SWEEP;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (w_load_ok) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + SEL_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef VMUX_STREAM_PARITY_EN
    logic r_out_parity;

    // Parity follows the loaded word; out-of-range loads carry zero data, hence zero parity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_parity <= 1'b0;
        end else if (w_load) begin
            r_out_parity <= ^w_pick_data;
        end
    end

    assign out_parity = r_out_parity;
`endif

    assign req_ready = w_req_ready;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_vmux_stream.sv
// Directed bench for vmux_stream: direct, backpressure, sweep, stalled sweep, reset mid-sweep, out-of-range (NUM_IN=3).
module tb_vmux_stream;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;

    logic [63:0] in_data;
    logic [1:0]  sel;
    logic        req_valid, req_ready, start;
    logic [15:0] out_data;
    logic [1:0]  out_tag;
    logic        out_err, out_valid, out_ready, busy, done;

    logic [47:0] in3;
    logic [1:0]  sel3;
    logic        req3, req_ready3, start3;
    logic [15:0] out_data3;
    logic [1:0]  out_tag3;
    logic        out_err3, out_valid3, out_ready3, busy3, done3;
`ifdef VMUX_STREAM_PARITY_EN
    logic        out_parity, out_parity3;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vmux_stream #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .sel(sel),
        .req_valid(req_valid), .req_ready(req_ready), .start(start),
        .out_data(out_data), .out_tag(out_tag), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef VMUX_STREAM_PARITY_EN
        .out_parity(out_parity),
`endif
        .busy(busy), .done(done)
    );

    vmux_stream #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_data(in3), .sel(sel3),
        .req_valid(req3), .req_ready(req_ready3), .start(start3),
        .out_data(out_data3), .out_tag(out_tag3), .out_err(out_err3),
        .out_valid(out_valid3), .out_ready(out_ready3),
`ifdef VMUX_STREAM_PARITY_EN
        .out_parity(out_parity3),
`endif
        .busy(busy3), .done(done3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_w [4];
    logic [1:0]  st_tag [5];
    logic        st_rdy [5];

    initial begin
        in_data = '0; sel = '0; req_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        in3 = '0; sel3 = '0; req3 = 1'b0; start3 = 1'b0; out_ready3 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_tag",   32'(out_tag),   32'd0);
        chk("rst_err",   32'(out_err),   32'd0);
        reset_n = 1'b1;
        tick();

        // Direct select of channel 2
        in_data   = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        sel       = 2'd2;
        req_valid = 1'b1;
        #1;
        chk("dir_ready", 32'(req_ready), 32'd1);
        tick();
        chk("dir_data",  32'(out_data),  32'hCCCC);
        chk("dir_tag",   32'(out_tag),   32'd2);
        chk("dir_valid", 32'(out_valid), 32'd1);
        chk("dir_err",   32'(out_err),   32'd0);
        req_valid = 1'b0;
        tick();
        chk("dir_drain", 32'(out_valid), 32'd0);

        // Backpressure: hold BBBB while a second request waits
        out_ready = 1'b0;
        sel       = 2'd1;
        req_valid = 1'b1;
        tick();
        chk("bp_load", 32'(out_data), 32'hBBBB);
        sel = 2'd3;
        #1;
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", 32'(out_data), 32'hBBBB);
            chk("bp_hold_tag",  32'(out_tag),  32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_high", 32'(req_ready), 32'd1);
        tick();
        chk("bp_next_data",  32'(out_data),  32'hDDDD);
        chk("bp_next_tag",   32'(out_tag),   32'd3);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        req_valid = 1'b0;
        tick();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // Sweep; simultaneous request must be refused, channel 3 changed before its load
        exp_w = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h1234};
        start     = 1'b1;
        req_valid = 1'b1;
        sel       = 2'd0;
        #1;
        chk("sw_req_blocked", 32'(req_ready), 32'd0);
        tick();
        start     = 1'b0;
        req_valid = 1'b0;
        chk("sw_busy_on",  32'(busy),      32'd1);
        chk("sw_no_req",   32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) in_data[63:48] = 16'h1234;
            tick();
            chk("sw_tag",   32'(out_tag),   32'(i));
            chk("sw_data",  32'(out_data),  32'(exp_w[i]));
            chk("sw_valid", 32'(out_valid), 32'd1);
            chk("sw_done",  32'(done),      (i == 3) ? 32'd1 : 32'd0);
            chk("sw_busy",  32'(busy),      (i == 3) ? 32'd0 : 32'd1);
        end
        in_data[63:48] = 16'hDDDD;
        tick();
        chk("sw_end_valid", 32'(out_valid), 32'd0);
        chk("sw_end_done",  32'(done),      32'd0);

        // Stalled sweep with a stray start mid-burst
        st_rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        st_tag = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("st_busy_on", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            out_ready = st_rdy[i];
            start     = (i == 2);
            tick();
            chk("st_tag",   32'(out_tag),   32'(st_tag[i]));
            chk("st_data",  32'(out_data),  32'(exp_w[st_tag[i]] == 16'h1234 ? 16'hDDDD : exp_w[st_tag[i]]));
            chk("st_valid", 32'(out_valid), 32'd1);
            chk("st_done",  32'(done),      (i == 4) ? 32'd1 : 32'd0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("st_end_busy",  32'(busy),      32'd0);
        chk("st_end_valid", 32'(out_valid), 32'd0);

        // Reset mid-sweep at idx=2
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mr_pre_tag", 32'(out_tag), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_busy",  32'(busy),      32'd0);
        chk("mr_done",  32'(done),      32'd0);
        chk("mr_data",  32'(out_data),  32'd0);
        chk("mr_tag",   32'(out_tag),   32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mr_no_done",  32'(done),      32'd0);
            chk("mr_no_valid", 32'(out_valid), 32'd0);
        end

        // Out-of-range select with NUM_IN=3
        in3  = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        sel3 = 2'd3;
        req3 = 1'b1;
        tick();
        chk("oor_data",  32'(out_data3),  32'd0);
        chk("oor_err",   32'(out_err3),   32'd1);
        chk("oor_tag",   32'(out_tag3),   32'd3);
        chk("oor_valid", 32'(out_valid3), 32'd1);
`ifdef VMUX_STREAM_PARITY_EN
        chk("oor_parity", 32'(out_parity3), 32'd0);
`endif
        sel3       = 2'd0;
        in3[15:0]  = 16'h0007;
        tick();
        chk("ir_data", 32'(out_data3), 32'h0007);
        chk("ir_err",  32'(out_err3),  32'd0);
        chk("ir_tag",  32'(out_tag3),  32'd0);
`ifdef VMUX_STREAM_PARITY_EN
        chk("ir_parity", 32'(out_parity3), 32'd1);
`endif
        req3 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vmux_stream.md
Name: vmux_stream

Overview:
- Parametrised, registered N:1 operand selector for the vector datapath; successor of the combinational 4:1 16-bit selector.
- Two modes:
  - direct: one selected word per handshake.
  - sweep: streams all N inputs in index order as a vector burst to the memory-to-memory write port.
- Output is registered with valid/ready flow control and carries the source-index tag.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- NUM_IN, 4, number of input channels (2..16).
- SEL_W, 2, select/tag width; must satisfy 2**SEL_W >= NUM_IN; checked by elaboration assertion.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; channel k at bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel index for direct mode.
- req_valid  input  1  direct-mode request.
- req_ready  output  1  direct request accepted when req_valid && req_ready.
- start  input  1  one-cycle sweep launch.
- out_data  output  WIDTH  registered selected word.
- out_tag  output  SEL_W  channel index of out_data.
- out_err  output  1  out_data came from an out-of-range select.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts beat when out_valid && out_ready.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse when final sweep beat is loaded.

Behaviour:
- Reset (reset_n=0, async, immediate): out_data=0, out_tag=0, out_err=0, out_valid=0, busy=0, done=0, state=IDLE, idx=0. Reset mid-sweep abandons the burst; no done pulse.
- load_ok = !out_valid || out_ready (output register free or draining this cycle).
- FSM states IDLE, SWEEP.
- IDLE:
  - req_ready = load_ok.
  - On req_valid && req_ready, next edge: out_data=in_data[sel], out_tag=sel, out_valid=1.
  - If sel >= NUM_IN: out_data=0, out_err=1; otherwise out_err=0.
  - Latency request -> out_valid = 1 cycle.
- start in IDLE: enter SWEEP, idx=0, busy=1 next cycle. Takes priority over a simultaneous req_valid; that request is not accepted (req_ready=0 that cycle whenever start=1).
- SWEEP:
  - req_ready=0; start ignored.
  - Each cycle with load_ok: out_data=in_data[idx], out_tag=idx, out_err=0, out_valid=1, idx increments.
  - Beat with idx==NUM_IN-1: done=1 for that cycle, return to IDLE, busy=0, idx=0.
  - in_data is sampled at each load, not snapshotted at start.
- out_valid clears when out_ready && out_valid and no new load occurs the same cycle. Load and drain in the same cycle keep out_valid=1 with new data (full throughput, one beat per cycle).
- Stall (out_valid=1, out_ready=0): out_data, out_tag, out_err held stable; idx held; no request accepted.
- done and busy are registered outputs.

Optional Feature:
- Macro VMUX_STREAM_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR-reduce of the word loaded into out_data.
  - Registered and held with out_data; reset 0.
  - Out-of-range beats have parity 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (WIDTH=16, NUM_IN=4, SEL_W=2 unless noted):
- Reset: drive reset_n=0 mid-sweep (idx=2) -> all outputs 0 immediately, state IDLE; after release, no done pulse.
- Direct: in_data={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}, sel=2, req_valid=1, out_ready=1 -> next cycle out_data=16'hCCCC, out_tag=2, out_valid=1, out_err=0.
- Backpressure: out_ready=0 with out_valid=1, req_valid=1 -> req_ready=0, out_data held over 5 cycles. Raise out_ready -> next beat loads same cycle as drain.
- Sweep: pulse start, out_ready=1 -> out_tag 0,1,2,3 on four consecutive cycles with matching data; done=1 coincident with tag-3 load; busy high for 4 cycles.
- Sweep stall plus simultaneous events: start and req_valid same cycle -> request not accepted. out_ready toggled 1,0,1 during sweep -> no beat lost or duplicated.
- Out-of-range, NUM_IN=3: sel=3 -> out_data=0, out_err=1, out_tag=3. With VMUX_STREAM_PARITY_EN, in_data[0]=16'h0007, sel=0 -> out_parity=1.
